// File: rtl/nibble_mux_arbiter.sv
// rtl/nibble_mux_arbiter.sv - round-robin arbiter sharing one 4-bit 2:1 mux between two valid/ready sources

module mux_2_1_4_bits (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       s,
  output logic [3:0] m
);

  // s=0 selects the X leg, s=1 the Y leg
  assign m = s ? y : x;

endmodule

module nibble_mux_arbiter #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_valid,
  input  logic [3:0] a_data,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [3:0] b_data,
  output logic       b_ready,
  output logic       m_valid,
  output logic [3:0] m_data,
  input  logic       m_ready,
  output logic       sel,
  output logic       grant_a,
  output logic       grant_b
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          last_b;
  logic          acc;
  logic          xfer;
  logic          dwell_done;
  logic [3:0]    mux_m;

  mux_2_1_4_bits u_mux (
    .x (a_data),
    .y (b_data),
    .s (sel),
    .m (mux_m)
  );

  // The output stage can take a nibble when empty or being drained this cycle
  assign acc        = ~m_valid | m_ready;
  assign a_ready    = grant_a & acc;
  assign b_ready    = grant_b & acc;
  assign xfer       = (a_valid & a_ready) | (b_valid & b_ready);
  assign dwell_done = xfer & (cnt == CNT_MAX);

  // Next owner from current-cycle valids; the owner keeps the mux until its dwell expires or it goes quiet
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (a_valid && b_valid) state_nxt = last_b ? OWN_A : OWN_B;
        else if (a_valid)       state_nxt = OWN_A;
        else if (b_valid)       state_nxt = OWN_B;
        else                    state_nxt = IDLE;
      end
      OWN_A: begin
        if ((dwell_done && b_valid) || (!a_valid && b_valid)) state_nxt = OWN_B;
        else if (!a_valid && !b_valid)                        state_nxt = IDLE;
        else                                                  state_nxt = OWN_A;
      end
      OWN_B: begin
        if ((dwell_done && a_valid) || (!b_valid && a_valid)) state_nxt = OWN_A;
        else if (!b_valid && !a_valid)                        state_nxt = IDLE;
        else                                                  state_nxt = OWN_B;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Arbiter state, registered grant/select outputs, dwell counter and output stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      last_b  <= 1'b1;
      cnt     <= '0;
      sel     <= 1'b0;
      grant_a <= 1'b0;
      grant_b <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= 4'h0;
    end else begin
      state   <= state_nxt;
      sel     <= (state_nxt == OWN_B);
      grant_a <= (state_nxt == OWN_A);
      grant_b <= (state_nxt == OWN_B);

      if (state == OWN_A)      last_b <= 1'b0;
      else if (state == OWN_B) last_b <= 1'b1;

      if (state_nxt != state)          cnt <= '0;
      else if (xfer && cnt != CNT_MAX) cnt <= cnt + CW'(1);

      if (xfer) begin
        m_data  <= mux_m;
        m_valid <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nibble_mux_arbiter.sv
// tb/tb_nibble_mux_arbiter.sv - self-checking bench for nibble_mux_arbiter

module tb_nibble_mux_arbiter;

  localparam int DW = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_valid, b_valid, m_ready;
  logic [3:0] a_data, b_data;
  logic       a_ready, b_ready, m_valid, sel, grant_a, grant_b;
  logic [3:0] m_data;

  logic       a_valid_2, b_valid_2, m_ready_2;
  logic [3:0] a_data_2, b_data_2;
  logic       a_ready_2, b_ready_2, m_valid_2, sel_2, grant_a_2, grant_b_2;
  logic [3:0] m_data_2;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  nibble_mux_arbiter #(.DWELL(DW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .sel(sel), .grant_a(grant_a), .grant_b(grant_b)
  );

  nibble_mux_arbiter #(.DWELL(1)) dut_2 (
    .clk(clk), .rst(rst),
    .a_valid(a_valid_2), .a_data(a_data_2), .a_ready(a_ready_2),
    .b_valid(b_valid_2), .b_data(b_data_2), .b_ready(b_ready_2),
    .m_valid(m_valid_2), .m_data(m_data_2), .m_ready(m_ready_2),
    .sel(sel_2), .grant_a(grant_a_2), .grant_b(grant_b_2)
  );

  typedef struct packed {
    logic       a_v;
    logic [3:0] a_d;
    logic       b_v;
    logic [3:0] b_d;
    logic       m_r;
    logic       e_a_r;
    logic       e_b_r;
    logic       e_m_v;
    logic [3:0] e_m_d;
    logic       e_sel;
    logic       e_g_a;
    logic       e_g_b;
  } vec_t;

  vec_t tbl [10];

  // reference model state: owner 0=none 1=A 2=B
  int         mdl_own, mdl_last, mdl_beats;
  logic       mdl_mv;
  logic [3:0] mdl_md;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_valid = 0; a_data = 0; b_valid = 0; b_data = 0; m_ready = 0;
    a_valid_2 = 0; a_data_2 = 0; b_valid_2 = 0; b_data_2 = 0; m_ready_2 = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mdl_own = 0; mdl_last = 2; mdl_beats = 0; mdl_mv = 0; mdl_md = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Advance the reference model by one clock using the inputs present this cycle
  task automatic model_step();
    bit acc, xa, xb, xf, me, peer;
    int own_n;
    acc = !mdl_mv || m_ready;
    xa  = (mdl_own == 1) && acc && a_valid;
    xb  = (mdl_own == 2) && acc && b_valid;
    xf  = xa || xb;
    if (mdl_own == 0) begin
      if (a_valid && b_valid) own_n = (mdl_last == 1) ? 2 : 1;
      else if (a_valid)       own_n = 1;
      else if (b_valid)       own_n = 2;
      else                    own_n = 0;
    end else begin
      me   = (mdl_own == 1) ? a_valid : b_valid;
      peer = (mdl_own == 1) ? b_valid : a_valid;
      if ((xf && mdl_beats == DW - 1 && peer) || (!me && peer)) own_n = 3 - mdl_own;
      else if (!me && !peer)                                    own_n = 0;
      else                                                      own_n = mdl_own;
    end
    if (own_n != mdl_own)          mdl_beats = 0;
    else if (xf && mdl_beats < DW - 1) mdl_beats = mdl_beats + 1;
    if (mdl_own != 0) mdl_last = mdl_own;
    if (xf) begin
      mdl_md = xa ? a_data : b_data;
      mdl_mv = 1'b1;
    end else if (m_ready) begin
      mdl_mv = 1'b0;
    end
    mdl_own = own_n;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string      exp_pat;
    byte        got;
    bit         a_acc, b_acc, e_acc;
    logic [3:0] alt_exp [4];

    // a_v a_d b_v b_d m_r | a_r b_r m_v m_d sel g_a g_b
    tbl[0] = '{1'b1, 4'h3, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 4'h3, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 4'h7, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 4'h7, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 4'h7, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 4'h7, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 4'h0, 1'b1, 4'h9, 1'b1, 1'b1, 1'b0, 1'b1, 4'h7, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 4'h0, 1'b1, 4'h9, 1'b1, 1'b0, 1'b1, 1'b0, 4'h7, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h9, 1'b1, 1'b0, 1'b1};
    tbl[9] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h9, 1'b0, 1'b0, 1'b0};

    // Reset state, first transfer latency, backpressure hold, owner hand-off, return to idle
    do_reset();
    for (int i = 0; i < 10; i++) begin
      a_valid = tbl[i].a_v; a_data = tbl[i].a_d;
      b_valid = tbl[i].b_v; b_data = tbl[i].b_d;
      m_ready = tbl[i].m_r;
      @(negedge clk);
      check($sformatf("tbl%0d a_ready", i), 8'(a_ready), 8'(tbl[i].e_a_r));
      check($sformatf("tbl%0d b_ready", i), 8'(b_ready), 8'(tbl[i].e_b_r));
      check($sformatf("tbl%0d m_valid", i), 8'(m_valid), 8'(tbl[i].e_m_v));
      check($sformatf("tbl%0d m_data", i),  8'(m_data),  8'(tbl[i].e_m_d));
      check($sformatf("tbl%0d sel", i),     8'(sel),     8'(tbl[i].e_sel));
      check($sformatf("tbl%0d grant_a", i), 8'(grant_a), 8'(tbl[i].e_g_a));
      check($sformatf("tbl%0d grant_b", i), 8'(grant_b), 8'(tbl[i].e_g_b));
      next_cycle();
    end

    // Continuous contention: beats by owner follow the dwell pattern with no bubble
    do_reset();
    exp_pat = "-AAAABBBBAAAA";
    a_valid = 1; b_valid = 1; m_ready = 1;
    for (int c = 0; c < exp_pat.len(); c++) begin
      a_data = 4'($urandom); b_data = 4'($urandom);
      @(negedge clk);
      got = (a_valid && a_ready) ? "A" : (b_valid && b_ready) ? "B" : "-";
      check($sformatf("dwell beat%0d", c), got, exp_pat[c]);
      next_cycle();
    end

    // DWELL=1 strict alternation on the second instance
    do_reset();
    a_valid_2 = 1; a_data_2 = 4'hA; b_valid_2 = 1; b_data_2 = 4'h5; m_ready_2 = 1;
    alt_exp[0] = 4'hA; alt_exp[1] = 4'h5; alt_exp[2] = 4'hA; alt_exp[3] = 4'h5;
    repeat (2) next_cycle();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("alt m_valid%0d", k), 8'(m_valid_2), 8'h1);
      check($sformatf("alt m_data%0d", k), 8'(m_data_2), 8'(alt_exp[k]));
      next_cycle();
    end

    // Asynchronous reset while B owns a pending nibble
    do_reset();
    b_valid = 1; b_data = 4'h6; m_ready = 0;
    repeat (2) next_cycle();
    @(negedge clk);
    check("pre-rst grant_b", 8'(grant_b), 8'h1);
    check("pre-rst m_valid", 8'(m_valid), 8'h1);
    #1 rst = 1'b1;
    #1;
    check("rst m_valid", 8'(m_valid), 8'h0);
    check("rst m_data", 8'(m_data), 8'h0);
    check("rst grant_b", 8'(grant_b), 8'h0);
    check("rst sel", 8'(sel), 8'h0);
    next_cycle();
    rst = 1'b0;
    a_valid = 1; a_data = 4'h1; b_valid = 1; b_data = 4'h2; m_ready = 1;
    next_cycle();
    @(negedge clk);
    check("tie grant_a", 8'(grant_a), 8'h1);
    check("tie grant_b", 8'(grant_b), 8'h0);

    // Randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      e_acc = !mdl_mv || m_ready;
      check("rnd a_ready", 8'(a_ready), 8'((mdl_own == 1) && e_acc));
      check("rnd b_ready", 8'(b_ready), 8'((mdl_own == 2) && e_acc));
      check("rnd m_valid", 8'(m_valid), 8'(mdl_mv));
      check("rnd m_data",  8'(m_data),  8'(mdl_md));
      check("rnd sel",     8'(sel),     8'(mdl_own == 2));
      check("rnd grant_a", 8'(grant_a), 8'(mdl_own == 1));
      check("rnd grant_b", 8'(grant_b), 8'(mdl_own == 2));
      a_acc = a_valid && (mdl_own == 1) && e_acc;
      b_acc = b_valid && (mdl_own == 2) && e_acc;
      model_step();
      next_cycle();
      if (a_acc || !a_valid) begin
        a_valid = ($urandom_range(0, 3) != 0);
        a_data  = 4'($urandom);
      end
      if (b_acc || !b_valid) begin
        b_valid = ($urandom_range(0, 3) != 0);
        b_data  = 4'($urandom);
      end
      m_ready = ($urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
